// File: rtl/distri_fifo.sv
// distri_fifo: synchronous FIFO built on a distributed (async-read) RAM.
// Full/empty come from wrap-bit pointers. Optional occupancy output level_o is
// enabled by defining DFIFO_LEVEL_EN.
// ENTRY_NUM must be a power of two and at least 2.

// distri_ram: register-array storage with synchronous write and combinational read.
module distri_ram #(
    parameter int unsigned ENTRY_NUM = 32,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned AWDTH     = $clog2(ENTRY_NUM)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AWDTH-1:0] write_addr_i,
    input  logic [AWDTH-1:0] read_addr_i,
    input  logic [XLEN-1:0]  data_i,
    output logic [XLEN-1:0]  data_o
);

    logic [XLEN-1:0] r_mem [ENTRY_NUM];

    // Write port; contents are deliberately never reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[write_addr_i] <= data_i;
        end
    end

    assign data_o = r_mem[read_addr_i];

endmodule

module distri_fifo #(
    parameter int unsigned ENTRY_NUM = 32,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned AWDTH     = $clog2(ENTRY_NUM)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             s_valid_i,
    input  logic [XLEN-1:0]  s_data_i,
    output logic             s_ready_o,
    output logic             m_valid_o,
    output logic [XLEN-1:0]  m_data_o,
    input  logic             m_ready_i
`ifdef DFIFO_LEVEL_EN
    ,
    output logic [AWDTH:0]   level_o
`endif
);

    localparam logic [AWDTH:0] PtrOne = {{AWDTH{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AWDTH:0] r_wr_ptr;
    logic [AWDTH:0] r_rd_ptr;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AWDTH-1:0] == r_rd_ptr[AWDTH-1:0]) &&
                     (r_wr_ptr[AWDTH] != r_rd_ptr[AWDTH]);

    // Handshake outputs depend only on registered pointers.
    assign s_ready_o = !w_full;
    assign m_valid_o = !w_empty;

    assign w_push = s_valid_i && s_ready_o;
    assign w_pop  = m_valid_o && m_ready_i;

    // Pointer update; reset and flush both return to the empty state.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrOne;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrOne;
            end
        end
    end

    distri_ram #(
        .ENTRY_NUM (ENTRY_NUM),
        .XLEN      (XLEN),
        .AWDTH     (AWDTH)
    ) u_ram (
        .clk_i        (clk_i),
        .we_i         (w_push),
        .write_addr_i (r_wr_ptr[AWDTH-1:0]),
        .read_addr_i  (r_rd_ptr[AWDTH-1:0]),
        .data_i       (s_data_i),
        .data_o       (m_data_o)
    );

`ifdef DFIFO_LEVEL_EN
    logic [AWDTH:0] r_level;

    // Occupancy counter tracking push/pop; simultaneous push and pop cancel.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_level <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + PtrOne;
                2'b01:   r_level <= r_level - PtrOne;
                default: r_level <= r_level;
            endcase
        end
    end

    assign level_o = r_level;
`endif

endmodule
